// File: rtl/freq_div_prog_if.sv
// Control and status bundle for the programmable multi-channel clock divider.
interface freq_div_prog_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DW     = 8,
    parameter int unsigned CW     = 2
);
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              cfg_we;
    logic [CW-1:0]     cfg_ch;
    logic [DW-1:0]     cfg_div;
    logic [NUM_CH-1:0] CLK_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend;

    // Controller side: drives enables, realign and divisor writes.
    modport master (
        output en, sync, cfg_we, cfg_ch, cfg_div,
        input  CLK_out, tick, pend
    );

    // Divider side.
    modport slave (
        input  en, sync, cfg_we, cfg_ch, cfg_div,
        output CLK_out, tick, pend
    );
endinterface

// File: rtl/freq_div_prog.sv
// Multi-channel programmable clock divider: per-channel divisor, enable,
// period-boundary divisor updates and a global phase-realign pulse.
module freq_div_prog #(
    parameter int unsigned             NUM_CH   = 3,
    parameter int unsigned             DW       = 8,
    parameter int unsigned             CW       = 2,
    parameter logic [NUM_CH*DW-1:0]    DIV_INIT = {8'd100, 8'd10, 8'd2}
) (
    input  logic           CLK_in,
    input  logic           RST,
    freq_div_prog_if.slave bus
);

    // Divisors below 2 cannot produce a toggling output, so they become 2.
    function automatic logic [DW-1:0] f_clamp(input logic [DW-1:0] d);
        return (d < DW'(2)) ? DW'(2) : d;
    endfunction

    logic [DW-1:0]     r_cnt   [NUM_CH];
    logic [DW-1:0]     r_dcur  [NUM_CH];
    logic [DW-1:0]     r_dpend [NUM_CH];
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_clk;
    logic [NUM_CH-1:0] r_tick;

    logic [DW:0]       w_half    [NUM_CH];
    logic [DW:0]       w_cnt_inc [NUM_CH];
    logic [NUM_CH-1:0] w_wrap;
    logic [NUM_CH-1:0] w_wr;

    // Per-channel high-phase length, next count, wrap and write-select decode.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_half[i]    = ({1'b0, r_dcur[i]} + (DW+1)'(1)) >> 1;
            w_cnt_inc[i] = {1'b0, r_cnt[i]} + (DW+1)'(1);
            w_wrap[i]    = (r_cnt[i] == (r_dcur[i] - DW'(1)));
            w_wr[i]      = bus.cfg_we && (bus.cfg_ch == CW'(i));
        end
    end

    // Counter, output phase and divisor staging; a write only touches the
    // pending divisor so the running period always finishes cleanly.
    always_ff @(posedge CLK_in or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_dcur[i]  <= f_clamp(DIV_INIT[i*DW +: DW]);
                r_dpend[i] <= f_clamp(DIV_INIT[i*DW +: DW]);
                // Start on the last count so the first enabled edge wraps.
                r_cnt[i]   <= f_clamp(DIV_INIT[i*DW +: DW]) - DW'(1);
            end
            r_pend <= '0;
            r_clk  <= '0;
            r_tick <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (bus.sync || (bus.en[i] && w_wrap[i])) begin
                    r_cnt[i]  <= '0;
                    r_clk[i]  <= 1'b1;
                    r_tick[i] <= 1'b1;
                    if (r_pend[i]) begin
                        r_dcur[i] <= r_dpend[i];
                        r_pend[i] <= 1'b0;
                    end
                end else if (!bus.en[i]) begin
                    r_tick[i] <= 1'b0;
                end else begin
                    r_cnt[i]  <= w_cnt_inc[i][DW-1:0];
                    r_clk[i]  <= (w_cnt_inc[i] < w_half[i]);
                    r_tick[i] <= 1'b0;
                end
                // A same-edge write overrides the pend clear above.
                if (w_wr[i]) begin
                    r_dpend[i] <= f_clamp(bus.cfg_div);
                    r_pend[i]  <= 1'b1;
                end
            end
        end
    end

    assign bus.CLK_out = r_clk;
    assign bus.tick    = r_tick;
    assign bus.pend    = r_pend;

endmodule
